// File: rtl/piradip_bit_serial_phy_if.sv
// Bit-stream and pin bundle for piradip_bit_serial_phy.
// The slave modport is the PHY; the master modport is the stream source/sink plus the far end of the pins.
interface piradip_bit_serial_phy_if;
   logic tx_tvalid;
   logic tx_tready;
   logic tx_tdata;
   logic tx_tlast;
   logic rx_tvalid;
   logic rx_tready;
   logic rx_tdata;
   logic rx_tlast;
   logic busy;
   logic sclk;
   logic sdo;
   logic csn;
   logic sdi;

   modport master (
      output tx_tvalid, tx_tdata, tx_tlast, rx_tready, sdi,
      input  tx_tready, rx_tvalid, rx_tdata, rx_tlast, busy, sclk, sdo, csn
   );

   modport slave (
      input  tx_tvalid, tx_tdata, tx_tlast, rx_tready, sdi,
      output tx_tready, rx_tvalid, rx_tdata, rx_tlast, busy, sclk, sdo, csn
   );
endinterface

// File: rtl/piradip_bit_serial_phy.sv
// Bit-stream <-> SPI-style pin PHY: drives sclk/sdo/csn MSB-first and returns sampled sdi bits.
// Optional macro PIRADIP_SERIAL_PHY_LOOPBACK_EN adds i_loopback to sample the internal sdo instead of sdi.
module piradip_bit_serial_phy #(
   parameter int unsigned CLK_DIV = 4,
   parameter int unsigned CS_GAP  = 2,
   parameter bit          CPOL    = 1'b0
) (
   input  logic                           i_aclk,
   input  logic                           i_areset,
`ifdef PIRADIP_SERIAL_PHY_LOOPBACK_EN
   input  logic                           i_loopback,
`endif
   piradip_bit_serial_phy_if.slave        io_phy
);

   localparam logic [7:0] DIV_RELOAD = 8'(CLK_DIV - 1);
   localparam logic [7:0] GAP_RELOAD = 8'(CS_GAP - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LEAD  = 3'd1,
      S_HIGH  = 3'd2,
      S_LOW   = 3'd3,
      S_PAUSE = 3'd4,
      S_TRAIL = 3'd5,
      S_GAP   = 3'd6
   } state_t;

   state_t     r_state;
   logic [7:0] r_cnt;
   logic       r_sclk;
   logic       r_sdo;
   logic       r_csn;
   logic       r_last;
   logic       r_busy;
   logic       r_rx_valid;
   logic       r_rx_data;
   logic       r_rx_last;

   state_t     w_state_nxt;
   logic [7:0] w_cnt_nxt;
   logic       w_sclk_nxt;
   logic       w_csn_nxt;
   logic       w_accept;
   logic       w_sample;
   logic       w_sample_bit;
   logic       w_expired;
   logic       w_slot_free;

   assign w_expired   = (r_cnt == 8'd0);
   // The slot may refill on the very edge it drains, so a pending drain counts as free.
   assign w_slot_free = (~r_rx_valid) | io_phy.rx_tready;

`ifdef PIRADIP_SERIAL_PHY_LOOPBACK_EN
   assign w_sample_bit = i_loopback ? r_sdo : io_phy.sdi;
`else
   assign w_sample_bit = io_phy.sdi;
`endif

   // Next-state, divider reload and per-bit accept/sample strobes.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = w_expired ? r_cnt : (r_cnt - 8'd1);
      w_sclk_nxt  = r_sclk;
      w_csn_nxt   = r_csn;
      w_accept    = 1'b0;
      w_sample    = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_csn_nxt  = 1'b1;
            w_sclk_nxt = CPOL;
            if (io_phy.tx_tvalid) begin
               w_accept    = 1'b1;
               w_csn_nxt   = 1'b0;
               w_state_nxt = S_LEAD;
               w_cnt_nxt   = DIV_RELOAD;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_LEAD, S_LOW: begin
            // With the slot full the counter parks at zero and sclk holds idle: no edge is lost.
            if (w_expired && w_slot_free) begin
               w_sample    = 1'b1;
               w_sclk_nxt  = ~CPOL;
               w_state_nxt = S_HIGH;
               w_cnt_nxt   = DIV_RELOAD;
            end else begin
               w_state_nxt = r_state;
            end
         end
         S_HIGH: begin
            if (w_expired) begin
               w_sclk_nxt = CPOL;
               if (r_last) begin
                  w_state_nxt = S_TRAIL;
                  w_cnt_nxt   = DIV_RELOAD;
               end else if (io_phy.tx_tvalid) begin
                  w_accept    = 1'b1;
                  w_state_nxt = S_LOW;
                  w_cnt_nxt   = DIV_RELOAD;
               end else begin
                  w_state_nxt = S_PAUSE;
               end
            end else begin
               w_state_nxt = S_HIGH;
            end
         end
         S_PAUSE: begin
            if (io_phy.tx_tvalid) begin
               w_accept    = 1'b1;
               w_state_nxt = S_LOW;
               w_cnt_nxt   = DIV_RELOAD;
            end else begin
               w_state_nxt = S_PAUSE;
            end
         end
         S_TRAIL: begin
            if (w_expired) begin
               w_csn_nxt   = 1'b1;
               w_state_nxt = S_GAP;
               w_cnt_nxt   = GAP_RELOAD;
            end else begin
               w_state_nxt = S_TRAIL;
            end
         end
         S_GAP: begin
            if (w_expired) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_state_nxt = S_GAP;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_csn_nxt   = 1'b1;
            w_sclk_nxt  = CPOL;
         end
      endcase
   end

   // State, pin and divider registers.
   always_ff @(posedge i_aclk or posedge i_areset) begin
      if (i_areset) begin
         r_state <= S_IDLE;
         r_cnt   <= 8'd0;
         r_sclk  <= CPOL;
         r_sdo   <= 1'b0;
         r_csn   <= 1'b1;
         r_last  <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_sclk  <= w_sclk_nxt;
         r_csn   <= w_csn_nxt;
         r_busy  <= (w_state_nxt != S_IDLE);
         if (w_accept) begin
            r_sdo  <= io_phy.tx_tdata;
            r_last <= io_phy.tx_tlast;
         end
      end
   end

   // Single-entry RX slot; a sample on the same edge as a drain wins.
   always_ff @(posedge i_aclk or posedge i_areset) begin
      if (i_areset) begin
         r_rx_valid <= 1'b0;
         r_rx_data  <= 1'b0;
         r_rx_last  <= 1'b0;
      end else if (w_sample) begin
         r_rx_valid <= 1'b1;
         r_rx_data  <= w_sample_bit;
         r_rx_last  <= r_last;
      end else if (io_phy.rx_tready) begin
         r_rx_valid <= 1'b0;
      end
   end

   assign io_phy.tx_tready = w_accept;
   assign io_phy.rx_tvalid = r_rx_valid;
   assign io_phy.rx_tdata  = r_rx_data;
   assign io_phy.rx_tlast  = r_rx_last;
   assign io_phy.busy      = r_busy;
   assign io_phy.sclk      = r_sclk;
   assign io_phy.sdo       = r_sdo;
   assign io_phy.csn       = r_csn;

endmodule

// File: tb/tb_piradip_bit_serial_phy.sv
// Scoreboard bench for piradip_bit_serial_phy: a CPOL=0 unit (sdi looped to sdo) and a CPOL=1 unit.
// Expected RX bits and frame shapes are queued at stimulus time and popped by negedge monitors.
module tb_piradip_bit_serial_phy;
   localparam int DIV0 = 4;
   localparam int GAP0 = 2;
   localparam int DIV1 = 2;
   localparam int GAP1 = 3;

   logic aclk;
   logic areset;
   logic sdi_zero;
   logic loopback0;
   logic loopback1;

   int n_checks;
   int n_errors;

   piradip_bit_serial_phy_if if0 ();
   piradip_bit_serial_phy_if if1 ();

   assign if0.sdi = sdi_zero ? 1'b0 : if0.sdo;
   assign if1.sdi = if1.sdo;

   piradip_bit_serial_phy #(.CLK_DIV(DIV0), .CS_GAP(GAP0), .CPOL(1'b0)) dut0 (
      .i_aclk     (aclk),
      .i_areset   (areset),
`ifdef PIRADIP_SERIAL_PHY_LOOPBACK_EN
      .i_loopback (loopback0),
`endif
      .io_phy     (if0)
   );

   piradip_bit_serial_phy #(.CLK_DIV(DIV1), .CS_GAP(GAP1), .CPOL(1'b1)) dut1 (
      .i_aclk     (aclk),
      .i_areset   (areset),
`ifdef PIRADIP_SERIAL_PHY_LOOPBACK_EN
      .i_loopback (loopback1),
`endif
      .io_phy     (if1)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   // Expected RX bits as {last, data}; expected frames as sclk rise count and csn-low length (-1 = any).
   logic [1:0] q0[$];
   logic [1:0] q1[$];
   int         fq_rises[$];
   int         fq_len[$];
   int         rx_cnt0;
   int         rx_cnt1;

   task automatic chk(input string name, input bit ok, input int act, input int req);
      n_checks = n_checks + 1;
      if (!ok) begin
         n_errors = n_errors + 1;
         $display("FAIL %s: got %0d required %0d", name, act, req);
      end
   endtask

   task automatic chk_eq(input string name, input int act, input int req);
      chk(name, act == req, act, req);
   endtask

   // RX scoreboard, sclk pulse shape and frame shape for unit 0.
   logic [1:0] e0;
   logic       prev_sclk0;
   logic       prev_csn0;
   logic       prev_blocked0;
   logic       seen0;
   int         hi0;
   int         rises0;
   int         lo_csn0;
   int         hi_csn0;
   initial begin
      prev_sclk0 = 1'b0; prev_csn0 = 1'b1; prev_blocked0 = 1'b0; seen0 = 1'b0;
      hi0 = 0; rises0 = 0; lo_csn0 = 0; hi_csn0 = 0; rx_cnt0 = 0;
   end
   always @(negedge aclk) begin
      if (if0.rx_tvalid === 1'b1 && if0.rx_tready === 1'b1) begin
         rx_cnt0 = rx_cnt0 + 1;
         if (q0.size() == 0) begin
            chk("rx0_unexpected_bit", 1'b0, int'(if0.rx_tdata), -1);
         end else begin
            e0 = q0.pop_front();
            chk_eq("rx0_data", int'(if0.rx_tdata), int'(e0[0]));
            chk_eq("rx0_last", int'(if0.rx_tlast), int'(e0[1]));
         end
      end
      if (areset) begin
         hi0 = 0;
      end else begin
         if (if0.sclk && !prev_sclk0) begin
            rises0 = rises0 + 1;
            chk_eq("sclk0_edge_while_slot_full", int'(prev_blocked0), 0);
         end
         if (if0.sclk) begin
            hi0 = hi0 + 1;
         end else if (prev_sclk0) begin
            chk_eq("sclk0_high_width", hi0, DIV0);
            hi0 = 0;
         end
      end
      prev_sclk0    = if0.sclk;
      prev_blocked0 = if0.rx_tvalid && !if0.rx_tready;
      if (!if0.csn) begin
         if (prev_csn0) begin
            if (seen0) chk("csn0_gap_min", hi_csn0 >= GAP0, hi_csn0, GAP0);
            rises0  = 0;
            lo_csn0 = 0;
         end
         lo_csn0 = lo_csn0 + 1;
      end else begin
         if (!prev_csn0) begin
            seen0 = 1'b1;
            if (fq_rises.size() == 0) begin
               chk("frame0_unexpected", 1'b0, rises0, -1);
            end else begin
               int er;
               int el;
               er = fq_rises.pop_front();
               el = fq_len.pop_front();
               chk_eq("frame0_sclk_pulses", rises0, er);
               if (el >= 0) chk_eq("frame0_csn_low_cycles", lo_csn0, el);
            end
            hi_csn0 = 0;
         end
         hi_csn0 = hi_csn0 + 1;
      end
      prev_csn0 = if0.csn;
   end

   // RX scoreboard for unit 1.
   logic [1:0] e1;
   initial rx_cnt1 = 0;
   always @(negedge aclk) begin
      if (if1.rx_tvalid === 1'b1 && if1.rx_tready === 1'b1) begin
         rx_cnt1 = rx_cnt1 + 1;
         if (q1.size() == 0) begin
            chk("rx1_unexpected_bit", 1'b0, int'(if1.rx_tdata), -1);
         end else begin
            e1 = q1.pop_front();
            chk_eq("rx1_data", int'(if1.rx_tdata), int'(e1[0]));
            chk_eq("rx1_last", int'(if1.rx_tlast), int'(e1[1]));
         end
      end
   end

   task automatic send_bit(input logic d, input logic l, input bit expect_rx);
      bit done;
      if0.tx_tdata  = d;
      if0.tx_tlast  = l;
      if0.tx_tvalid = 1'b1;
      if (expect_rx) q0.push_back({l, d});
      done = 1'b0;
      for (int t = 0; t < 400 && !done; t++) begin
         @(negedge aclk);
         if (if0.tx_tready) done = 1'b1;
      end
      if (!done) chk("tx0_accept_timeout", 1'b0, 0, 1);
      @(posedge aclk);
      #1;
      if0.tx_tvalid = 1'b0;
   endtask

   task automatic send_frame(input int n, input logic [15:0] bits, input int csn_len);
      logic [15:0] b;
      b = bits;
      fq_rises.push_back(n);
      fq_len.push_back(csn_len);
      for (int i = 0; i < n; i++) send_bit(b[n-1-i], (i == n - 1), 1'b1);
   endtask

   task automatic wait_idle;
      bit done;
      done = 1'b0;
      for (int t = 0; t < 500 && !done; t++) begin
         @(posedge aclk);
         #1;
         if (!if0.busy && !if0.rx_tvalid) done = 1'b1;
      end
      if (!done) chk("idle_timeout", 1'b0, 0, 1);
   endtask

   task automatic check_reset_state(input string tag);
      chk_eq({tag, "_csn"}, int'(if0.csn), 1);
      chk_eq({tag, "_sclk"}, int'(if0.sclk), 0);
      chk_eq({tag, "_sdo"}, int'(if0.sdo), 0);
      chk_eq({tag, "_tx_tready"}, int'(if0.tx_tready), 0);
      chk_eq({tag, "_rx_tvalid"}, int'(if0.rx_tvalid), 0);
      chk_eq({tag, "_rx_tdata"}, int'(if0.rx_tdata), 0);
      chk_eq({tag, "_rx_tlast"}, int'(if0.rx_tlast), 0);
      chk_eq({tag, "_busy"}, int'(if0.busy), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int base;
      int rdy1;
      int falls1;
      int lo1;
      logic prev1;
      n_checks = 0;
      n_errors = 0;
      areset    = 1'b1;
      sdi_zero  = 1'b0;
      loopback0 = 1'b0;
      loopback1 = 1'b0;
      if0.tx_tvalid = 1'b0; if0.tx_tdata = 1'b0; if0.tx_tlast = 1'b0; if0.rx_tready = 1'b1;
      if1.tx_tvalid = 1'b0; if1.tx_tdata = 1'b0; if1.tx_tlast = 1'b0; if1.rx_tready = 1'b1;
      repeat (3) @(posedge aclk);
      #1;
      check_reset_state("reset");
      chk_eq("reset_sclk1_idle_high", int'(if1.sclk), 1);
      chk_eq("reset_csn1", int'(if1.csn), 1);
      areset = 1'b0;

      // Frame A (exact csn length) immediately followed by frame B with a 20-cycle TX pause after bit 2.
      send_frame(4, 16'b1011, DIV0 * (2 * 4 + 1));
      fq_rises.push_back(4);
      fq_len.push_back(-1);
      send_bit(1'b1, 1'b0, 1'b1);
      send_bit(1'b1, 1'b0, 1'b1);
      repeat (20) @(posedge aclk);
      #1;
      chk_eq("pause_csn_low", int'(if0.csn), 0);
      chk_eq("pause_sclk_idle", int'(if0.sclk), 0);
      chk_eq("pause_busy", int'(if0.busy), 1);
      chk_eq("pause_sdo_hold", int'(if0.sdo), 1);
      send_bit(1'b0, 1'b0, 1'b1);
      send_bit(1'b1, 1'b1, 1'b1);
      wait_idle();
      chk_eq("idle_busy_after_b", int'(if0.busy), 0);

      // Frame C: RX consumer stalls after bit 1 is delivered.
      base = rx_cnt0;
      fork
         send_frame(4, 16'b0110, -1);
         begin
            bit got;
            got = 1'b0;
            for (int t = 0; t < 300 && !got; t++) begin
               @(posedge aclk);
               if (rx_cnt0 == base + 1) got = 1'b1;
            end
            if (!got) chk("stall_first_bit_timeout", 1'b0, rx_cnt0 - base, 1);
            #1;
            if0.rx_tready = 1'b0;
            repeat (30) @(posedge aclk);
            #1;
            chk_eq("stall_slot_full", int'(if0.rx_tvalid), 1);
            chk_eq("stall_slot_bit2", int'(if0.rx_tdata), 1);
            chk_eq("stall_sclk_low", int'(if0.sclk), 0);
            chk_eq("stall_csn_low", int'(if0.csn), 0);
            if0.rx_tready = 1'b1;
         end
      join
      wait_idle();

      // Frame D: reset in the middle of the high phase of bit 3 while the slot holds that bit.
      fq_rises.push_back(3);
      fq_len.push_back(-1);
      send_bit(1'b1, 1'b0, 1'b1);
      send_bit(1'b0, 1'b0, 1'b1);
      send_bit(1'b1, 1'b0, 1'b0);
      if0.rx_tready = 1'b0;
      repeat (5) @(posedge aclk);
      #1;
      chk_eq("pre_abort_slot_full", int'(if0.rx_tvalid), 1);
      chk_eq("pre_abort_sclk_high", int'(if0.sclk), 1);
      #2;
      areset = 1'b1;
      #1;
      chk_eq("abort_csn_async", int'(if0.csn), 1);
      chk_eq("abort_sclk_async", int'(if0.sclk), 0);
      chk_eq("abort_rx_tvalid", int'(if0.rx_tvalid), 0);
      repeat (2) @(posedge aclk);
      #1;
      areset = 1'b0;
      if0.rx_tready = 1'b1;
      check_reset_state("post_abort");
      send_frame(2, 16'b01, DIV0 * (2 * 2 + 1));
      wait_idle();

      // Unit 1: single-bit frame, CPOL=1, tx_tvalid held through the whole frame.
      if1.tx_tdata  = 1'b0;
      if1.tx_tlast  = 1'b1;
      if1.tx_tvalid = 1'b1;
      q1.push_back(2'b10);
      rdy1 = 0; falls1 = 0; lo1 = 0;
      prev1 = if1.sclk;
      for (int i = 0; i < 20; i++) begin
         @(negedge aclk);
         if (if1.tx_tready) rdy1 = rdy1 + 1;
         if (!if1.sclk) lo1 = lo1 + 1;
         if (prev1 && !if1.sclk) falls1 = falls1 + 1;
         prev1 = if1.sclk;
         if (i == 7) if1.tx_tvalid = 1'b0;
      end
      chk_eq("single_tx_tready_cycles", rdy1, 1);
      chk_eq("single_sclk_low_pulses", falls1, 1);
      chk_eq("single_sclk_low_width", lo1, DIV1);
      chk_eq("single_sclk_idle_high", int'(if1.sclk), 1);
      chk_eq("single_csn_released", int'(if1.csn), 1);
      chk_eq("single_rx_bits", rx_cnt1, 1);

`ifdef PIRADIP_SERIAL_PHY_LOOPBACK_EN
      // Loopback: sdi forced low, RX must still carry 0xA5.
      loopback0 = 1'b1;
      sdi_zero  = 1'b1;
      send_frame(8, 16'h00A5, DIV0 * (2 * 8 + 1));
      wait_idle();
      loopback0 = 1'b0;
      sdi_zero  = 1'b0;
`endif

      repeat (4) @(posedge aclk);
      #1;
      chk_eq("rx0_queue_drained", q0.size(), 0);
      chk_eq("rx1_queue_drained", q1.size(), 0);
      chk_eq("frame_queue_drained", fq_rises.size(), 0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
